mold_feed_arb: RTL

- Packet-atomic arbiter sharing one moldudp64 decoder between two redundant UDP feeds (line A / line B).
- Sits between the two UDP/AXI-stream receive paths and the decoder's udp_axis_* input.
- Grants whole packets round-robin and never interleaves beats of different packets.
- Truncates runaway packets at MAX_BEATS, so a stuck feed cannot starve the other.

---
 rtl/mold_feed_arb.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mold_feed_arb.sv
// mold_feed_arb
// Packet-atomic arbiter that shares one moldudp64 decoder between two
// redundant UDP feeds (line A / line B). Whole packets are granted, and beats
// of different packets never interleave. A packet longer than MAX_BEATS is cut
// short: its last forwarded beat is marked tlast=1/tuser=1, and the rest of it
// is drained from the source without being forwarded.
//
// Ports:
//   clk, nreset            clock, asynchronous active-low reset
//   a_axis_* / b_axis_*    feed A / feed B receive streams (tready_o back)
//   udp_axis_*             stream to the decoder (tready_i from decoder)
//   grant_o                current owner, 0 = A, 1 = B (valid while busy_o)
//   busy_o                 a packet is in progress (FWD or DRAIN)
//   drop_cnt_o             saturating count of truncated packets
//   state_o                debug view of the FSM state (IDLE/FWD/DRAIN)
//
// Optional build macro: MOLD_ARB_FIXED_PRIO_EN
//   defined   -> IDLE always prefers A; B is granted only when A is not valid
//   undefined -> round-robin between A and B when both are valid
//
// Handshake: a beat moves on a port only in a cycle where tvalid and tready
// are both high. Sources must hold tvalid/tdata/tkeep/tlast/tuser stable until
// that happens. The arbiter never makes tready depend on a non-granted feed.
module mold_feed_arb #(
    parameter int AXI_DATA_W = 64,
    parameter int AXI_KEEP_W = AXI_DATA_W / 8,
    parameter int MAX_BEATS  = 190,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  nreset,

    input  logic                  a_axis_tvalid_i,
    input  logic [AXI_KEEP_W-1:0] a_axis_tkeep_i,
    input  logic [AXI_DATA_W-1:0] a_axis_tdata_i,
    input  logic                  a_axis_tlast_i,
    input  logic                  a_axis_tuser_i,
    output logic                  a_axis_tready_o,

    input  logic                  b_axis_tvalid_i,
    input  logic [AXI_KEEP_W-1:0] b_axis_tkeep_i,
    input  logic [AXI_DATA_W-1:0] b_axis_tdata_i,
    input  logic                  b_axis_tlast_i,
    input  logic                  b_axis_tuser_i,
    output logic                  b_axis_tready_o,

    output logic                  udp_axis_tvalid_o,
    output logic [AXI_KEEP_W-1:0] udp_axis_tkeep_o,
    output logic [AXI_DATA_W-1:0] udp_axis_tdata_o,
    output logic                  udp_axis_tlast_o,
    output logic                  udp_axis_tuser_o,
    input  logic                  udp_axis_tready_i,

    output logic                  grant_o,
    output logic                  busy_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o,
    output logic [1:0]            state_o
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FWD   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]            state_q,    state_d;
    logic                  grant_q,    grant_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
`ifndef MOLD_ARB_FIXED_PRIO_EN
    logic                  last_grant_q, last_grant_d;
`endif

    // Granted feed, selected by the registered owner.
    logic                  sel_valid;
    logic [AXI_KEEP_W-1:0] sel_keep;
    logic [AXI_DATA_W-1:0] sel_data;
    logic                  sel_last;
    logic                  sel_user;
    logic                  sel_ready;
    logic                  trunc;
    logic                  pick;

    assign sel_valid = grant_q ? b_axis_tvalid_i : a_axis_tvalid_i;
    assign sel_keep  = grant_q ? b_axis_tkeep_i  : a_axis_tkeep_i;
    assign sel_data  = grant_q ? b_axis_tdata_i  : a_axis_tdata_i;
    assign sel_last  = grant_q ? b_axis_tlast_i  : a_axis_tlast_i;
    assign sel_user  = grant_q ? b_axis_tuser_i  : a_axis_tuser_i;

    // The beat at position MAX_BEATS (count MAX_BEATS-1) is the last one
    // allowed out; if the source does not end the packet there, end it here.
    assign trunc = (state_q == ST_FWD) &&
                   (beat_cnt_q == CNT_W'(MAX_BEATS - 1)) && !sel_last;

    // Owner chosen in IDLE; only meaningful when at least one feed is valid.
`ifdef MOLD_ARB_FIXED_PRIO_EN
    assign pick = ~a_axis_tvalid_i;
`else
    assign pick = (a_axis_tvalid_i && b_axis_tvalid_i) ? ~last_grant_q
                                                       : ~a_axis_tvalid_i;
`endif

    always_comb begin
        udp_axis_tvalid_o = 1'b0;
        udp_axis_tkeep_o  = sel_keep;
        udp_axis_tdata_o  = sel_data;
        udp_axis_tlast_o  = sel_last | trunc;
        udp_axis_tuser_o  = sel_user | trunc;
        sel_ready         = 1'b0;
        case (state_q)
            ST_FWD: begin
                udp_axis_tvalid_o = sel_valid;
                sel_ready         = udp_axis_tready_i;
            end
            // Discard the remainder of a truncated packet at full rate.
            ST_DRAIN: sel_ready = 1'b1;
            default: ;
        endcase
        a_axis_tready_o = sel_ready & ~grant_q;
        b_axis_tready_o = sel_ready &  grant_q;
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        drop_cnt_d = drop_cnt_q;
`ifndef MOLD_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (a_axis_tvalid_i || b_axis_tvalid_i) begin
                    state_d    = ST_FWD;
                    grant_d    = pick;
                    beat_cnt_d = '0;
`ifndef MOLD_ARB_FIXED_PRIO_EN
                    last_grant_d = pick;
`endif
                end
            end
            ST_FWD: begin
                if (sel_valid && udp_axis_tready_i) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    if (sel_last) begin
                        state_d = ST_IDLE;
                    end else if (trunc) begin
                        state_d = ST_DRAIN;
                        if (drop_cnt_q != {DROP_CNT_W{1'b1}}) begin
                            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (sel_valid && sel_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b0;
            beat_cnt_q <= '0;
            drop_cnt_q <= '0;
`ifndef MOLD_ARB_FIXED_PRIO_EN
            // Start as if B went last so that A wins the first contest.
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            drop_cnt_q <= drop_cnt_d;
`ifndef MOLD_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign grant_o    = grant_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign drop_cnt_o = drop_cnt_q;
    assign state_o    = state_q;

endmodule
